// File: rtl/rr_grant_scheduler16_pkg.sv
// Shared constants and state encoding for the 16-way round-robin grant scheduler.
package rr_grant_scheduler16_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;
endpackage

// File: rtl/rr_grant_scheduler16_if.sv
// Request/grant bundle between the requesters and the scheduler.
interface rr_grant_scheduler16_if;
    import rr_grant_scheduler16_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (output req, input grant, grant_idx, grant_valid, timeout);
    modport slave  (input req, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_grant_scheduler16_dec.sv
// 4-to-16 one-hot decoder with enable; turns the registered owner index into grant lines.
module grant_decoder4x16
    import rr_grant_scheduler16_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] dec
);
    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
        assign dec[i] = en && (idx == IDX_W'(i));
    end
endmodule

// File: rtl/rr_grant_scheduler16.sv
// Round-robin scheduler for 16 requesters with a registered owner index,
// a mandatory dead cycle between owners and an optional hold-time limit.
module rr_grant_scheduler16
    import rr_grant_scheduler16_pkg::*;
#(
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rr_grant_scheduler16_if.slave  bus
);
    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EN ? MAX_HOLD - 1 : 0);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  pick;

    // Rotate so the slot after the last owner sits at bit 0, then take the lowest set bit.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] start;
        logic [N_REQ-1:0] rot;
        logic [IDX_W-1:0] off;
        start = last + IDX_W'(1);
        rot   = N_REQ'({r, r} >> start);
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return start + off;
    endfunction

    assign pick = rr_pick(bus.req, last_idx_q);

    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_idx_d   = pick;
                    last_idx_d    = pick;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                // A voluntary drop wins over the hold limit, so no timeout pulse then.
                if (!bus.req[grant_idx_q]) begin
                    grant_valid_d = 1'b0;
                    state_d       = RELEASE;
                end else if (HOLD_EN && hold_cnt_q == HOLD_LAST) begin
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_idx_q    <= IDX_W'(N_REQ - 1);
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

    grant_decoder4x16 u_dec (
        .idx (grant_idx_q),
        .en  (grant_valid_q),
        .dec (bus.grant)
    );
endmodule

// File: tb/tb_rr_grant_scheduler16.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs, compared 1 time unit after the edge.
module tb_rr_grant_scheduler16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_grant_scheduler16_if bus();
    rr_grant_scheduler16_if bus2();

    rr_grant_scheduler16 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_grant_scheduler16 #(.MAX_HOLD(0), .HOLD_W(8)) dut_nl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic       vld;
        logic [3:0] idx;
        logic       to;
    } exp_t;

    typedef struct {
        logic [15:0] r;
        logic        v;
        logic [3:0]  i;
        logic        t;
    } row_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [15:0] onehot(input logic v, input logic [3:0] i);
        logic [15:0] one;
        one = 16'h0001;
        return v ? (one << i) : 16'h0000;
    endfunction

    task automatic push(input logic v, input logic [3:0] i, input logic t);
        exp_t x;
        x.vld = v; x.idx = i; x.to = t;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [15:0] r, input logic v, input logic [3:0] i, input logic t);
        @(negedge clk);
        bus.req = r;
        push(v, i, t);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        bus2.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        row_t tail [2];
        tail[0] = '{16'h0000, 1'b0, 4'd0, 1'b0};
        tail[1] = '{16'h0000, 1'b0, 4'd0, 1'b0};
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.grant !== 16'h0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 4'd0 || bus.timeout !== 1'b0)
            $display("FAIL reset_hold: grant=%h vld=%b idx=%0d to=%b, expected all zero",
                     bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) drive(tail[k-1].r, tail[k-1].v, tail[k-1].i, tail[k-1].t);
            e = sb.pop_front();
            n_chk++;
            if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to)
                $display("FAIL reset_release[%0d]: grant=%h vld=%b to=%b, expected grant=%h vld=%b to=%b",
                         k, bus.grant, bus.grant_valid, bus.timeout, onehot(e.vld, e.idx), e.vld, e.to);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0]  own [4];
        logic [15:0] r;
        own[0] = 4'd0; own[1] = 4'd8; own[2] = 4'd15; own[3] = 4'd0;
        apply_reset();
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 5; c++) begin
                r = 16'h8101;
                if (c == 3) r[own[o]] = 1'b0;
                drive(r, (c < 3), own[o], 1'b0);
                e = sb.pop_front();
                n_chk++;
                if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to ||
                    (e.vld && bus.grant_idx !== e.idx))
                    $display("FAIL rotation[%0d.%0d]: grant=%h vld=%b idx=%0d to=%b, expected grant=%h vld=%b idx=%0d to=%b",
                             o, c, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout,
                             onehot(e.vld, e.idx), e.vld, e.idx, e.to);
                else n_pass++;
            end
        end
        drive(16'h0000, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_wrap();
        row_t tbl [15];
        tbl[0]  = '{16'h8000, 1'b1, 4'd15, 1'b0};
        tbl[1]  = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[3]  = '{16'h0006, 1'b1, 4'd1,  1'b0};
        tbl[4]  = '{16'h0004, 1'b0, 4'd0,  1'b0};
        tbl[5]  = '{16'h0004, 1'b0, 4'd0,  1'b0};
        tbl[6]  = '{16'h0004, 1'b1, 4'd2,  1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[8]  = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[9]  = '{16'h0080, 1'b1, 4'd7,  1'b0};
        tbl[10] = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[11] = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[12] = '{16'h0181, 1'b1, 4'd8,  1'b0};
        tbl[13] = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[14] = '{16'h0000, 1'b0, 4'd0,  1'b0};
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].i, tbl[k].t);
            e = sb.pop_front();
            n_chk++;
            if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to ||
                (e.vld && bus.grant_idx !== e.idx))
                $display("FAIL wrap[%0d]: grant=%h vld=%b idx=%0d to=%b, expected grant=%h vld=%b idx=%0d to=%b",
                         k, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout,
                         onehot(e.vld, e.idx), e.vld, e.idx, e.to);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        row_t tbl [9];
        for (int k = 0; k < 9; k++) tbl[k] = '{16'h0010, 1'b1, 4'd4, 1'b0};
        tbl[4] = '{16'h0010, 1'b0, 4'd4, 1'b1};
        tbl[5] = '{16'h0010, 1'b0, 4'd4, 1'b0};
        tbl[7] = '{16'h0000, 1'b0, 4'd4, 1'b0};
        tbl[8] = '{16'h0000, 1'b0, 4'd4, 1'b0};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].i, tbl[k].t);
            e = sb.pop_front();
            n_chk++;
            if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to ||
                (e.vld && bus.grant_idx !== e.idx))
                $display("FAIL timeout[%0d]: grant=%h vld=%b idx=%0d to=%b, expected grant=%h vld=%b idx=%0d to=%b",
                         k, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout,
                         onehot(e.vld, e.idx), e.vld, e.idx, e.to);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        row_t tbl [6];
        for (int k = 0; k < 4; k++) tbl[k] = '{16'h0020, 1'b1, 4'd5, 1'b0};
        tbl[4] = '{16'h0000, 1'b0, 4'd5, 1'b0};
        tbl[5] = '{16'h0000, 1'b0, 4'd5, 1'b0};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].i, tbl[k].t);
            e = sb.pop_front();
            n_chk++;
            if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to ||
                (e.vld && bus.grant_idx !== e.idx))
                $display("FAIL collision[%0d]: grant=%h vld=%b idx=%0d to=%b, expected grant=%h vld=%b idx=%0d to=%b",
                         k, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout,
                         onehot(e.vld, e.idx), e.vld, e.idx, e.to);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        row_t tbl [5];
        for (int ph = 0; ph < 2; ph++) begin
            tbl[0] = '{16'h0200, 1'b1, 4'd9, 1'b0};
            tbl[1] = '{16'h0200, 1'b1, 4'd9, 1'b0};
            tbl[2] = (ph == 0) ? '{16'h0200, 1'b1, 4'd9, 1'b0} : '{16'h0401, 1'b1, 4'd0, 1'b0};
            tbl[3] = '{16'h0000, 1'b0, 4'd0, 1'b0};
            tbl[4] = '{16'h0000, 1'b0, 4'd0, 1'b0};
            apply_reset();
            for (int k = 0; k < 5; k++) begin
                if (k == 2) begin
                    #2;
                    rst_n = 1'b0;
                    bus.req = '0;
                    #1;
                    n_chk++;
                    if (bus.grant !== 16'h0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 4'd0 || bus.timeout !== 1'b0)
                        $display("FAIL mid_reset_async[%0d]: grant=%h vld=%b idx=%0d to=%b, expected all zero",
                                 ph, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
                    else n_pass++;
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                drive(tbl[k].r, tbl[k].v, tbl[k].i, tbl[k].t);
                e = sb.pop_front();
                n_chk++;
                if (bus.grant !== onehot(e.vld, e.idx) || bus.grant_valid !== e.vld || bus.timeout !== e.to ||
                    (e.vld && bus.grant_idx !== e.idx))
                    $display("FAIL mid_reset[%0d.%0d]: grant=%h vld=%b idx=%0d to=%b, expected grant=%h vld=%b idx=%0d to=%b",
                             ph, k, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout,
                             onehot(e.vld, e.idx), e.vld, e.idx, e.to);
                else n_pass++;
            end
        end
    endtask

    task automatic test_no_limit();
        logic on;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            on = (k < 12);
            @(negedge clk);
            bus2.req = on ? 16'h0001 : 16'h0000;
            push(on, 4'd0, 1'b0);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_chk++;
            if (bus2.grant !== onehot(e.vld, e.idx) || bus2.grant_valid !== e.vld || bus2.timeout !== e.to)
                $display("FAIL no_limit[%0d]: grant=%h vld=%b to=%b, expected grant=%h vld=%b to=%b",
                         k, bus2.grant, bus2.grant_valid, bus2.timeout, onehot(e.vld, e.idx), e.vld, e.to);
            else n_pass++;
        end
        bus2.req = '0;
    endtask

    initial begin
        bus.req  = '0;
        bus2.req = '0;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_collision();
        test_mid_reset();
        test_no_limit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_grant_scheduler16.md
# rr_grant_scheduler16

Round-robin scheduler that shares one 16-way resource among 16 requesters. It selects one requester at a time and holds a registered 4-bit grant index plus a valid flag. These registered signals drive an internal 4-to-16 one-hot decoder, which produces the per-requester grant lines. The block sits between the request sources and the shared datapath, sequencing access with an optional hold-time limit.

## Interface
Parameters:
- MAX_HOLD, 255: maximum consecutive cycles a grant is held before forced release. 0 disables the limit.
- HOLD_W, 8: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on clk.
- req  input  16  request vector. req[i] high means requester i wants the resource; it stays high while using it.
- grant  output  16  one-hot grant. grant[i] = grant_valid & (grant_idx == i).
- grant_idx  output  4  registered index of the current owner.
- grant_valid  output  1  registered; high while a grant is active.
- timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- State machine with states IDLE, GRANT, RELEASE. Reset state is IDLE.
- Internal last_idx (4 bits) holds the most recently granted index. Reset value is 15, so requester 0 has top priority after reset.
- IDLE
  - If req == 0, stay in IDLE.
  - Otherwise, search from (last_idx+1) mod 16 upward with wrap-around. Take the first i with req[i] = 1.
  - Load grant_idx = i and last_idx = i, set grant_valid = 1, clear hold_cnt, go to GRANT.
- GRANT
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - If req[grant_idx] = 0: clear grant_valid, go to RELEASE.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: clear grant_valid, pulse timeout, go to RELEASE.
  - Otherwise stay in GRANT. Changes on other req bits are ignored while in GRANT.
- RELEASE
  - One dead cycle with grant_valid = 0, guaranteeing a gap between owners. Always go to IDLE next.
- Fairness:
  - A requester is re-granted only after every other asserted requester has been served once, because the search starts just past the previous owner.
  - A timed-out requester that keeps req high waits its turn like any other.
- Single requester: the same index may be re-granted after the RELEASE and IDLE cycles.
- grant is a pure decode of registered signals. When grant_valid = 0, grant is all zero.

## Timing
- Reset values: grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0, state = IDLE, last_idx = 15, hold_cnt = 0.
- Reset mid-grant: all outputs clear asynchronously; the next arbitration after release restarts from requester 0.
- Grant latency: req seen in IDLE at edge n gives grant_valid = 1 after edge n (one cycle).
- Release latency: req[grant_idx] seen low at edge n gives grant_valid = 0 after edge n.
- Handoff spacing: a requester dropping req at edge n gives RELEASE after n, IDLE after n+1, new grant after n+2. Owner-to-owner gap is 2 cycles with grant_valid low.
- Timeout: with MAX_HOLD = M, grant_valid is high for exactly M cycles. timeout is high for the one cycle in which grant_valid first reads 0.
- Simultaneous events:
  - req drop and hold limit on the same cycle: treat as a normal release, no timeout pulse.
  - New requests arriving during RELEASE are considered in the following IDLE cycle.
- Wrap-around: with last_idx = 15, the search order is 0..15. With last_idx = 7, it is 8..15, then 0..7.

## Structure
- A shared package holds:
  - state encoding constants: IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2;
  - N_REQ = 16 and IDX_W = 4.
- Natural sub-module: grant_decoder4x16. It is a combinational 4-to-16 one-hot decoder with enable, driven by grant_idx and grant_valid.
- The round-robin search is a rotate-then-priority-encode function inside the top module, not a separate module.

## Test plan
- Reset: hold rst_n low with req = 16'hFFFF. Required: grant = 0 and grant_valid = 0. After release, grant = 16'h0001 (index 0) one cycle later.
- Rotation: req = 16'h8101 constant, each owner drops req for 1 cycle after 3 cycles of use. Required: grant order idx 0, 8, 15, 0, with 2 idle cycles between owners.
- Wrap-around: last owner 15, then req = 16'h0006. Required: next grant_idx = 1, then 2.
- Timeout: MAX_HOLD = 4, req = 16'h0010 held constantly. Required: grant_valid high for 4 cycles, timeout pulses once, re-grant of idx 4 two cycles later.
- Drop/limit collision: MAX_HOLD = 4, owner drops req on the 4th grant cycle. Required: release with timeout staying 0.
- Mid-grant reset: assert rst_n low asynchronously while idx 9 is granted. Required: grant clears immediately. After release with req = 16'h0200, idx 9 is granted without waiting for other requesters.
